dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the processor load/store path and a debug/loader master.
- The debug/loader master initialises data memory or dumps results for test-value checks.
- Sits between the processor's ALU-out/write-data/MemWrite signals and the data memory, on the same clock.
- Performs one memory access per cycle; supports debug bursts, CPU stalling and debug anti-starvation.

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU load/store path and a debug/loader master.
// Optional build macro DMEM_ARB_STATS_EN adds saturating grant/stall statistics counters.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [LEN_W-1:0]  dbg_len,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       cpu_gnt_cnt,
    output logic [15:0]       dbg_gnt_cnt,
    output logic [15:0]       stall_cnt,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] S_FREE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [0:0]        state, state_nxt;
    logic [LEN_W-1:0]  beat_cnt, beat_nxt;
    logic [ADDR_W-1:0] base_addr, base_nxt;
    logic [WAIT_W-1:0] dbg_wait;

    logic              cpu_win, dbg_win, first_beat;
    logic [LEN_W-1:0]  first_cnt;
    logic [ADDR_W-1:0] dbg_beat_addr;

    assign first_cnt = (dbg_len == '0) ? '0 : dbg_len - LEN_W'(1);

    // Grants are suppressed while rst is high so an in-flight burst vanishes at once
    always_comb begin
        cpu_win    = 1'b0;
        dbg_win    = 1'b0;
        first_beat = 1'b0;
        if (!rst) begin
            case (state)
                S_FREE: begin
                    if (dbg_req && (!cpu_req || dbg_wait == WAIT_W'(MAX_WAIT))) begin
                        dbg_win    = 1'b1;
                        first_beat = 1'b1;
                    end else if (cpu_req) begin
                        cpu_win = 1'b1;
                    end
                end
                S_BURST: dbg_win = dbg_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        base_nxt  = base_addr;
        case (state)
            S_FREE: begin
                if (first_beat) begin
                    base_nxt  = dbg_addr + ADDR_W'(4);
                    beat_nxt  = first_cnt;
                    state_nxt = (first_cnt != '0) ? S_BURST : S_FREE;
                end
            end
            S_BURST: begin
                if (dbg_req) begin
                    base_nxt = base_addr + ADDR_W'(4);
                    beat_nxt = beat_cnt - LEN_W'(1);
                    if (beat_cnt == LEN_W'(1)) state_nxt = S_FREE;
                end else begin
                    state_nxt = S_FREE;
                    beat_nxt  = '0;
                end
            end
            default: state_nxt = S_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FREE;
            beat_cnt  <= '0;
            base_addr <= '0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            base_addr <= base_nxt;
        end
    end

    // Anti-starvation: a losing debug request ages until it is forced through
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dbg_wait <= '0;
        else if (!dbg_req || dbg_win)
            dbg_wait <= '0;
        else if (dbg_wait != WAIT_W'(MAX_WAIT))
            dbg_wait <= dbg_wait + WAIT_W'(1);
    end

    assign dbg_beat_addr = (state == S_FREE) ? dbg_addr : base_addr;

    assign cpu_gnt   = cpu_win;
    assign dbg_gnt   = dbg_win;
    assign cpu_stall = cpu_req & ~cpu_win & ~rst;
    assign dbg_done  = first_beat ? (first_cnt == '0)
                                  : (dbg_win && beat_cnt == LEN_W'(1));

    assign mem_we    = (cpu_win & cpu_we) | (dbg_win & dbg_we);
    assign mem_addr  = cpu_win ? cpu_addr  : (dbg_win ? dbg_beat_addr : '0);
    assign mem_wdata = cpu_win ? cpu_wdata : (dbg_win ? dbg_wdata     : '0);
    assign cpu_rdata = cpu_win ? mem_rdata : '0;
    assign dbg_rdata = dbg_win ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_gnt_cnt <= '0;
            dbg_gnt_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (cpu_gnt && cpu_gnt_cnt != 16'hFFFF) cpu_gnt_cnt <= cpu_gnt_cnt + 16'd1;
            if (dbg_gnt && dbg_gnt_cnt != 16'hFFFF) dbg_gnt_cnt <= dbg_gnt_cnt + 16'd1;
            if (cpu_stall && stall_cnt != 16'hFFFF) stall_cnt   <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle expected strobes go through a scoreboard queue.
// A small word-addressed memory model supplies mem_rdata combinationally.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        cpu_gnt;
        logic        cpu_stall;
        logic        dbg_gnt;
        logic        dbg_done;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr;
    logic [3:0]  dbg_len;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt, dbg_done;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cpu_gnt_cnt, dbg_gnt_cnt, stall_cnt;
`endif

    logic [31:0] mem [1024];
    obs_t        sb[$];
    obs_t        got, want;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
`ifdef DMEM_ARB_STATS_EN
        .cpu_gnt_cnt(cpu_gnt_cnt), .dbg_gnt_cnt(dbg_gnt_cnt), .stall_cnt(stall_cnt),
`endif
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    function automatic obs_t sample();
        return '{cpu_gnt, cpu_stall, dbg_gnt, dbg_done, mem_we, mem_addr, mem_wdata};
    endfunction

    function automatic obs_t mk(input logic cg, input logic st, input logic dg, input logic dn,
                                input logic we, input logic [31:0] a, input logic [31:0] d);
        return '{cg, st, dg, dn, we, a, d};
    endfunction

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] a,
                           input logic [3:0] len, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_len = len; dbg_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0, 0);
        #2;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        got = sample(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_fail++; $display("FAIL reset_idle: got %h want %h", got, want); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpu_only();
        set_cpu(1, 1, 32'h40, 32'hDEADBEEF);
        sb.push_back(mk(1, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF));
        #1; got = sample(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_fail++; $display("FAIL cpu_write: got %h want %h", got, want); end
        @(negedge clk);
        set_cpu(1, 0, 32'h40, 0);
        sb.push_back(mk(1, 0, 0, 0, 0, 32'h40, 0));
        #1; got = sample(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_fail++; $display("FAIL cpu_read: got %h want %h", got, want); end
        n_cmp++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL cpu_rdata: got %h want deadbeef", cpu_rdata);
        end
        @(negedge clk);
        set_cpu(0, 0, 0, 0);
    endtask

    task automatic test_dbg_burst();
        // write burst 1..4; dbg_addr is scrambled after the first beat to prove it is ignored
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                set_dbg(1, 1, (k == 0) ? 32'h100 : 32'hBAD0, 4'd4, 32'(k + 1));
                sb.push_back(mk(0, 0, 1, k == 3, 1, 32'h100 + 32'(4 * k), 32'(k + 1)));
            end else begin
                set_dbg(0, 0, 0, 0, 0);
                sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            end
            #1; got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL burst_wr k=%0d: got %h want %h", k, got, want); end
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            set_dbg(1, 0, 32'h100, 4'd4, 0);
            sb.push_back(mk(0, 0, 1, k == 3, 0, 32'h100 + 32'(4 * k), 0));
            #1; got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL burst_rd k=%0d: got %h want %h", k, got, want); end
            n_cmp++;
            if (dbg_rdata !== 32'(k + 1)) begin
                n_fail++; $display("FAIL burst_rdata k=%0d: got %h want %h", k, dbg_rdata, k + 1);
            end
            @(negedge clk);
        end
        set_dbg(0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_contention();
        set_cpu(1, 0, 32'h40, 0);
        for (int k = 0; k < 12; k++) begin
            if (k < 11) set_dbg(1, 1, 32'h200, 4'd3, 32'h10 + 32'(k - 8));
            else        set_dbg(0, 0, 0, 0, 0);
            if (k < 8 || k == 11)
                sb.push_back(mk(1, 0, 0, 0, 0, 32'h40, 0));
            else
                sb.push_back(mk(0, 1, 1, k == 10, 1, 32'h200 + 32'(4 * (k - 8)), 32'h10 + 32'(k - 8)));
            #1; got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL contention k=%0d: got %h want %h", k, got, want); end
            @(negedge clk);
        end
        set_cpu(0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_abort();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0, 1: begin
                    set_dbg(1, 1, 32'h300, 4'd6, 32'h30 + 32'(k));
                    sb.push_back(mk(0, 0, 1, 0, 1, 32'h300 + 32'(4 * k), 32'h30 + 32'(k)));
                end
                2: begin
                    set_dbg(0, 0, 32'h300, 4'd6, 0);
                    set_cpu(1, 0, 32'h40, 0);
                    sb.push_back(mk(0, 1, 0, 0, 0, 0, 0));
                end
                3: sb.push_back(mk(1, 0, 0, 0, 0, 32'h40, 0));
                default: begin
                    set_cpu(0, 0, 0, 0);
                    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                end
            endcase
            #1; got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL abort k=%0d: got %h want %h", k, got, want); end
            if (k == 3) begin
                n_cmp++;
                if (cpu_rdata !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL abort_cpu_rdata: got %h want deadbeef", cpu_rdata);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0, 1: begin
                    set_dbg(1, 1, 32'h400, 4'd8, 32'h40 + 32'(k));
                    sb.push_back(mk(0, 0, 1, 0, 1, 32'h400 + 32'(4 * k), 32'h40 + 32'(k)));
                    #1;
                end
                2: begin
                    set_dbg(1, 1, 32'h400, 4'd8, 32'h42);
                    #1 rst = 1'b1;
                    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                end
                3: begin
                    rst = 1'b0;
                    set_dbg(0, 0, 0, 0, 0);
                    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                    #1;
                end
                default: begin
                    set_dbg(1, 1, 32'h0, 4'd1, 32'h77);
                    sb.push_back(mk(0, 0, 1, 1, 1, 32'h0, 32'h77));
                    #1;
                end
            endcase
            #1; got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL rst_mid k=%0d: got %h want %h", k, got, want); end
            @(negedge clk);
        end
        set_dbg(0, 0, 0, 0, 0);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        #1; got = sample(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_fail++; $display("FAIL rst_mid_after: got %h want %h", got, want); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin
                    set_dbg(1, 1, 32'hFFFFFFFC, 4'd0, 32'hA5);
                    sb.push_back(mk(0, 0, 1, 1, 1, 32'hFFFFFFFC, 32'hA5));
                end
                2: begin
                    set_dbg(1, 0, 32'hFFFFFFFC, 4'd2, 0);
                    sb.push_back(mk(0, 0, 1, 0, 0, 32'hFFFFFFFC, 0));
                end
                3: sb.push_back(mk(0, 0, 1, 1, 0, 32'h0, 0));
                default: begin
                    set_dbg(0, 0, 0, 0, 0);
                    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                end
            endcase
            #1; got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL wrap k=%0d: got %h want %h", k, got, want); end
            if (k == 2 || k == 3) begin
                n_cmp++;
                if (dbg_rdata !== ((k == 2) ? 32'hA5 : 32'h77)) begin
                    n_fail++; $display("FAIL wrap_rdata k=%0d: got %h want %h", k, dbg_rdata,
                                       (k == 2) ? 32'hA5 : 32'h77);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_cpu_only();
        test_dbg_burst();
        test_contention();
        test_abort();
        test_reset_mid_burst();
        test_wrap();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
